// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: loads a W x H image from IROM, applies host 2x2-window commands, streams the image to IRAM.
// Latency: load N+2 cycles after reset release; window/shift commands 2 cycles accept-to-ready; write N+2 cycles.
// Backpressure: busy=1 while loading or executing; cmd/cmd_valid are ignored whenever busy=1.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset (restarts LOAD)
//   cmd[3:0], cmd_valid   host command, accepted when cmd_valid=1 and busy=0
//   IROM_Q/IROM_rd/IROM_A image source; read data valid one cycle after address
//   IRAM_valid/D/A        image sink write port
//   busy, done            ready indication and one-cycle write-complete pulse
// Optional: define LCD_CTRL_PARAM_BRIGHT_EN to add saturating brighten (12) / darken (13).

module lcd_ctrl_param #(
   parameter int DW = 8,
   parameter int XW = 3,
   parameter int YW = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          cmd,
   input  logic                cmd_valid,
   input  logic [DW-1:0]       IROM_Q,
   output logic                IROM_rd,
   output logic [XW+YW-1:0]    IROM_A,
   output logic                IRAM_valid,
   output logic [DW-1:0]       IRAM_D,
   output logic [XW+YW-1:0]    IRAM_A,
   output logic                busy,
   output logic                done
);

   localparam int AW = XW + YW;
   localparam int N  = 1 << AW;

   localparam logic [AW-1:0] A_LAST = '1;
   localparam logic [AW-1:0] A_ONE  = AW'(1);
   localparam logic [AW:0]   C_ONE  = (AW+1)'(1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);
   localparam logic [XW-1:0] X_MAX  = '1;
   localparam logic [YW-1:0] Y_MAX  = '1;
   localparam logic [XW-1:0] X_HALF = XW'(1) << (XW - 1);
   localparam logic [YW-1:0] Y_HALF = YW'(1) << (YW - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_IDLE,
      S_EXEC,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // load_cnt has one extra bit: its MSB set means every IROM address has been issued
   logic [AW:0]   load_cnt_q, load_cnt_d;
   logic          cap_vld_q, cap_vld_d;
   logic [AW-1:0] cap_addr_q, cap_addr_d;
   logic          irom_rd_q, irom_rd_d;
   logic [AW-1:0] irom_a_q, irom_a_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          iram_vld_q, iram_vld_d;
   logic [AW-1:0] iram_a_q, iram_a_d;
   logic [DW-1:0] iram_d_q, iram_d_d;
   logic [XW-1:0] px_q, px_d;
   logic [YW-1:0] py_q, py_d;
   logic [3:0]    op_q, op_d;

   logic [DW-1:0] image_q [N];
   logic [DW-1:0] image_d [N];

   // window geometry and contents
   logic [XW-1:0] xm1;
   logic [YW-1:0] ym1;
   logic [AW-1:0] i0, i1, i2, i3;
   logic [DW-1:0] p0, p1, p2, p3;
   logic [DW-1:0] n0, n1, n2, n3;
   logic          win_we;
   logic [DW-1:0] m01, m23, mx;
   logic [DW-1:0] l01, l23, mn;
   logic [DW+1:0] sum;
   logic [DW-1:0] avg;

`ifdef LCD_CTRL_PARAM_BRIGHT_EN
   function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] p);
      return (p == '1) ? p : p + DW'(1);
   endfunction

   function automatic logic [DW-1:0] sat_dec(input logic [DW-1:0] p);
      return (p == '0) ? p : p - DW'(1);
   endfunction
`endif

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_LOAD;
         load_cnt_q <= '0;
         cap_vld_q  <= 1'b0;
         cap_addr_q <= '0;
         irom_rd_q  <= 1'b0;
         irom_a_q   <= '0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         iram_vld_q <= 1'b0;
         iram_a_q   <= '0;
         iram_d_q   <= '0;
         px_q       <= X_HALF;
         py_q       <= Y_HALF;
         op_q       <= '0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         cap_vld_q  <= cap_vld_d;
         cap_addr_q <= cap_addr_d;
         irom_rd_q  <= irom_rd_d;
         irom_a_q   <= irom_a_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         iram_vld_q <= iram_vld_d;
         iram_a_q   <= iram_a_d;
         iram_d_q   <= iram_d_d;
         px_q       <= px_d;
         py_q       <= py_d;
         op_q       <= op_d;
      end
   end

   // image contents are meaningless until reloaded, so no reset
   always_ff @(posedge clk) begin
      image_q <= image_d;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:  if (cap_vld_q && (cap_addr_q == A_LAST)) state_d = S_IDLE;
         S_IDLE:  if (cmd_valid) state_d = (cmd == 4'd0) ? S_WRITE : S_EXEC;
         S_EXEC:  state_d = S_IDLE;
         S_WRITE: if (iram_a_q == A_LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_LOAD;
      endcase
   end

   // ---------------------------------------------------------------- outputs / sequencing
   always_comb begin
      load_cnt_d = load_cnt_q;
      // IROM data returns one cycle after its address, so the capture slot trails the read
      cap_vld_d  = irom_rd_q;
      cap_addr_d = irom_a_q;
      irom_rd_d  = 1'b0;
      irom_a_d   = irom_a_q;
      iram_a_d   = iram_a_q;
      iram_d_d   = iram_d_q;
      op_d       = op_q;
      // busy only drops on entry to IDLE; every other state refuses commands
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      iram_vld_d = (state_d == S_WRITE);

      case (state_q)
         S_LOAD: begin
            if (!load_cnt_q[AW]) begin
               irom_rd_d  = 1'b1;
               irom_a_d   = load_cnt_q[AW-1:0];
               load_cnt_d = load_cnt_q + C_ONE;
            end
         end
         S_IDLE: begin
            if (cmd_valid) begin
               op_d = cmd;
               if (cmd == 4'd0) begin
                  iram_a_d = '0;
                  iram_d_d = image_q[0];
               end
            end
         end
         S_WRITE: begin
            if (state_d == S_WRITE) begin
               iram_a_d = iram_a_q + A_ONE;
               iram_d_d = image_q[iram_a_q + A_ONE];
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- window datapath
   assign xm1 = px_q - X_ONE;
   assign ym1 = py_q - Y_ONE;
   assign i0  = {ym1,  xm1};
   assign i1  = {ym1,  px_q};
   assign i2  = {py_q, xm1};
   assign i3  = {py_q, px_q};
   assign p0  = image_q[i0];
   assign p1  = image_q[i1];
   assign p2  = image_q[i2];
   assign p3  = image_q[i3];

   assign m01 = (p0 > p1) ? p0 : p1;
   assign m23 = (p2 > p3) ? p2 : p3;
   assign mx  = (m01 > m23) ? m01 : m23;
   assign l01 = (p0 < p1) ? p0 : p1;
   assign l23 = (p2 < p3) ? p2 : p3;
   assign mn  = (l01 < l23) ? l01 : l23;
   assign sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
   assign avg = DW'(sum >> 2);

   always_comb begin
      win_we = 1'b0;
      n0     = p0;
      n1     = p1;
      n2     = p2;
      n3     = p3;
      px_d   = px_q;
      py_d   = py_q;
      if (state_q == S_EXEC) begin
         case (op_q)
            4'd1: if (py_q > Y_ONE) py_d = py_q - Y_ONE;
            4'd2: if (py_q < Y_MAX) py_d = py_q + Y_ONE;
            4'd3: if (px_q > X_ONE) px_d = px_q - X_ONE;
            4'd4: if (px_q < X_MAX) px_d = px_q + X_ONE;
            4'd5: begin
               win_we = 1'b1;
               n0 = mx; n1 = mx; n2 = mx; n3 = mx;
            end
            4'd6: begin
               win_we = 1'b1;
               n0 = mn; n1 = mn; n2 = mn; n3 = mn;
            end
            4'd7: begin
               win_we = 1'b1;
               n0 = avg; n1 = avg; n2 = avg; n3 = avg;
            end
            4'd8: begin   // counter-clockwise
               win_we = 1'b1;
               n0 = p1; n1 = p3; n3 = p2; n2 = p0;
            end
            4'd9: begin   // clockwise
               win_we = 1'b1;
               n0 = p2; n2 = p3; n3 = p1; n1 = p0;
            end
            4'd10: begin  // mirror about the horizontal axis
               win_we = 1'b1;
               n0 = p2; n2 = p0; n1 = p3; n3 = p1;
            end
            4'd11: begin  // mirror about the vertical axis
               win_we = 1'b1;
               n0 = p1; n1 = p0; n2 = p3; n3 = p2;
            end
`ifdef LCD_CTRL_PARAM_BRIGHT_EN
            4'd12: begin
               win_we = 1'b1;
               n0 = sat_inc(p0); n1 = sat_inc(p1); n2 = sat_inc(p2); n3 = sat_inc(p3);
            end
            4'd13: begin
               win_we = 1'b1;
               n0 = sat_dec(p0); n1 = sat_dec(p1); n2 = sat_dec(p2); n3 = sat_dec(p3);
            end
`endif
            default: ;
         endcase
      end
   end

   // all four window writes land together and use the pre-update values
   always_comb begin
      image_d = image_q;
      if ((state_q == S_LOAD) && cap_vld_q) begin
         image_d[cap_addr_q] = IROM_Q;
      end
      if (win_we) begin
         image_d[i0] = n0;
         image_d[i1] = n1;
         image_d[i2] = n2;
         image_d[i3] = n3;
      end
   end

   assign IROM_rd    = irom_rd_q;
   assign IROM_A     = irom_a_q;
   assign IRAM_valid = iram_vld_q;
   assign IRAM_A     = iram_a_q;
   assign IRAM_D     = iram_d_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: default 8x8x8 instance plus a 16x4x10 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// Define LCD_CTRL_PARAM_BRIGHT_EN to exercise brighten/darken; otherwise 12/13 must be no-ops.

module tb_lcd_ctrl_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_test = 0;
   int n_fail = 0;

   // ---------------- default instance (8x8, DW=8)
   logic       rst1, cv1, rd1, wv1, busy1, done1;
   logic [3:0] cmd1;
   logic [7:0] irom_q1, wd1;
   logic [5:0] ra1, wa1;
   logic [7:0] rom1 [64];
   logic [7:0] ram1 [64];

   lcd_ctrl_param u_dut1 (
      .clk(clk), .reset(rst1), .cmd(cmd1), .cmd_valid(cv1),
      .IROM_Q(irom_q1), .IROM_rd(rd1), .IROM_A(ra1),
      .IRAM_valid(wv1), .IRAM_D(wd1), .IRAM_A(wa1),
      .busy(busy1), .done(done1)
   );

   always @(posedge clk) if (rd1) irom_q1 <= rom1[ra1];

   // ---------------- 16x4, DW=10 instance
   logic       rst2, cv2, rd2, wv2, busy2, done2;
   logic [3:0] cmd2;
   logic [9:0] irom_q2, wd2;
   logic [5:0] ra2, wa2;
   logic [9:0] rom2 [64];
   logic [9:0] ram2 [64];

   lcd_ctrl_param #(.DW(10), .XW(4), .YW(2)) u_dut2 (
      .clk(clk), .reset(rst2), .cmd(cmd2), .cmd_valid(cv2),
      .IROM_Q(irom_q2), .IROM_rd(rd2), .IROM_A(ra2),
      .IRAM_valid(wv2), .IRAM_D(wd2), .IRAM_A(wa2),
      .busy(busy2), .done(done2)
   );

   always @(posedge clk) if (rd2) irom_q2 <= rom2[ra2];

   // ---------------- stimulus helpers
   task automatic load1();
      int k;
      rst1 = 1'b1; cv1 = 1'b0;
      @(negedge clk);
      rst1 = 1'b0;
      k = 0;
      while (busy1 && k < 100) begin @(negedge clk); k++; end
      if (busy1) begin
         n_test++; n_fail++;
         $display("FAIL load1_timeout: busy=%0b after %0d cycles, required 0", busy1, k);
      end
   endtask

   task automatic cmd1_go(input logic [3:0] c);
      int k;
      cmd1 = c; cv1 = 1'b1;
      @(negedge clk);
      cv1 = 1'b0;
      k = 0;
      while (busy1 && k < 20) begin @(negedge clk); k++; end
      if (busy1) begin
         n_test++; n_fail++;
         $display("FAIL cmd1_timeout: busy=%0b for cmd %0d, required 0", busy1, c);
      end
   endtask

   task automatic write1(output int nwr, output int ndone, output int bad);
      nwr = 0; ndone = 0; bad = 0;
      cmd1 = 4'd0; cv1 = 1'b1;
      @(negedge clk);
      cv1 = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (wv1) begin
            if (wa1 != 6'(nwr)) bad++;
            ram1[wa1] = wd1;
            nwr++;
         end
         if (done1) begin
            ndone++;
            if (nwr != 64) bad++;
         end
         if (!busy1) break;
         @(negedge clk);
      end
   endtask

   task automatic load2(output int cyc);
      rst2 = 1'b1; cv2 = 1'b0;
      @(negedge clk);
      rst2 = 1'b0;
      cyc = 0;
      while (busy2 && cyc < 100) begin @(negedge clk); cyc++; end
   endtask

   task automatic cmd2_go(input logic [3:0] c);
      cmd2 = c; cv2 = 1'b1;
      @(negedge clk);
      cv2 = 1'b0;
      for (int k = 0; k < 20 && busy2; k++) @(negedge clk);
   endtask

   task automatic write2(output int nwr);
      nwr = 0;
      cmd2 = 4'd0; cv2 = 1'b1;
      @(negedge clk);
      cv2 = 1'b0;
      for (int k = 0; k < 200 && busy2; k++) begin
         if (wv2) begin ram2[wa2] = wd2; nwr++; end
         @(negedge clk);
      end
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      int bad, busy_at;
      @(negedge clk);   // reset has been sampled at least once
      n_test++; if (busy1 !== 1'b1)  begin n_fail++; $display("FAIL rst_busy: got %0b, required 1", busy1); end
      n_test++; if (done1 !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %0b, required 0", done1); end
      n_test++; if (rd1 !== 1'b0)    begin n_fail++; $display("FAIL rst_irom_rd: got %0b, required 0", rd1); end
      n_test++; if (ra1 !== 6'd0)    begin n_fail++; $display("FAIL rst_irom_a: got %0d, required 0", ra1); end
      n_test++; if (wv1 !== 1'b0)    begin n_fail++; $display("FAIL rst_iram_valid: got %0b, required 0", wv1); end
      n_test++; if (wa1 !== 6'd0)    begin n_fail++; $display("FAIL rst_iram_a: got %0d, required 0", wa1); end
      n_test++; if (wd1 !== 8'd0)    begin n_fail++; $display("FAIL rst_iram_d: got %0d, required 0", wd1); end
      rst1 = 1'b0;
      bad = 0; busy_at = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k <= 64 && (rd1 !== 1'b1 || ra1 !== 6'(k - 1))) bad++;
         if (k == 65 && rd1 !== 1'b0) bad++;
         if (busy1 === 1'b0) begin busy_at = k; break; end
      end
      n_test++; if (bad != 0)     begin n_fail++; $display("FAIL load_sweep: got %0d bad cycles, required 0", bad); end
      n_test++; if (busy_at != 66) begin n_fail++; $display("FAIL load_latency: got %0d cycles, required 66", busy_at); end
   endtask

   task automatic test_write();
      int nwr, nd, bad, dbad;
      write1(nwr, nd, bad);
      dbad = 0;
      for (int i = 0; i < 64; i++) if (ram1[i] !== 8'(i)) dbad++;
      n_test++; if (nwr != 64) begin n_fail++; $display("FAIL write_count: got %0d, required 64", nwr); end
      n_test++; if (nd != 1)   begin n_fail++; $display("FAIL write_done: got %0d pulses, required 1", nd); end
      n_test++; if (bad != 0)  begin n_fail++; $display("FAIL write_order: got %0d errors, required 0", bad); end
      n_test++; if (dbad != 0) begin n_fail++; $display("FAIL write_data: got %0d wrong pixels, required 0", dbad); end
   endtask

   task automatic test_max();
      int nwr, nd, bad;
      int idx [4] = '{27, 28, 35, 36};
      load1(); cmd1_go(4'd5); write1(nwr, nd, bad);
      for (int i = 0; i < 4; i++) begin
         n_test++;
         if (ram1[idx[i]] !== 8'd36) begin n_fail++; $display("FAIL max_px%0d: got %0d, required 36", idx[i], ram1[idx[i]]); end
      end
      n_test++; if (ram1[26] !== 8'd26) begin n_fail++; $display("FAIL max_px26: got %0d, required 26", ram1[26]); end
   endtask

   task automatic test_avg();
      int nwr, nd, bad;
      int idx [4] = '{27, 28, 35, 36};
      load1(); cmd1_go(4'd7); write1(nwr, nd, bad);
      for (int i = 0; i < 4; i++) begin
         n_test++;
         if (ram1[idx[i]] !== 8'd31) begin n_fail++; $display("FAIL avg_px%0d: got %0d, required 31", idx[i], ram1[idx[i]]); end
      end
   endtask

   task automatic test_rot_cw();
      int nwr, nd, bad;
      int idx [4] = '{27, 28, 35, 36};
      int exp [4] = '{35, 27, 36, 28};
      load1(); cmd1_go(4'd9); write1(nwr, nd, bad);
      for (int i = 0; i < 4; i++) begin
         n_test++;
         if (ram1[idx[i]] !== 8'(exp[i])) begin n_fail++; $display("FAIL rotcw_px%0d: got %0d, required %0d", idx[i], ram1[idx[i]], exp[i]); end
      end
   endtask

   task automatic test_boundary();
      int nwr, nd, bad;
      int idx [7] = '{0, 1, 8, 9, 2, 10, 16};
      int exp [7] = '{0, 0, 0, 0, 2, 10, 16};
      load1();
      for (int i = 0; i < 5; i++) cmd1_go(4'd3);
      for (int i = 0; i < 5; i++) cmd1_go(4'd1);
      cmd1_go(4'd6);
      write1(nwr, nd, bad);
      for (int i = 0; i < 7; i++) begin
         n_test++;
         if (ram1[idx[i]] !== 8'(exp[i])) begin n_fail++; $display("FAIL bound_px%0d: got %0d, required %0d", idx[i], ram1[idx[i]], exp[i]); end
      end
   endtask

   task automatic test_handshake();
      int nwr, nd, bad, acc;
      int idx [6] = '{29, 30, 37, 38, 39, 28};
      int exp [6] = '{38, 38, 38, 38, 39, 28};
      load1();
      acc = 0;
      cmd1 = 4'd4; cv1 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (busy1 === 1'b0) acc++;
         @(negedge clk);
      end
      cv1 = 1'b0;
      @(negedge clk);
      n_test++; if (acc != 10) begin n_fail++; $display("FAIL hs_accepts: got %0d, required 10", acc); end
      // one left shift, then cmd_valid stays high through the busy cycle
      cmd1 = 4'd3; cv1 = 1'b1;
      @(negedge clk);
      n_test++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL hs_busy: got %0b, required 1", busy1); end
      @(negedge clk);
      cv1 = 1'b0;
      n_test++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL hs_ready: got %0b, required 0", busy1); end
      cmd1_go(4'd5);
      write1(nwr, nd, bad);
      for (int i = 0; i < 6; i++) begin
         n_test++;
         if (ram1[idx[i]] !== 8'(exp[i])) begin n_fail++; $display("FAIL hs_px%0d: got %0d, required %0d", idx[i], ram1[idx[i]], exp[i]); end
      end
   endtask

   task automatic test_param();
      int cyc, nwr;
      int idx [6] = '{23, 24, 39, 40, 22, 41};
      int exp [6] = '{24, 23, 40, 39, 22, 41};
      int win [4] = '{23, 24, 39, 40};
      load2(cyc);
      n_test++; if (cyc != 66) begin n_fail++; $display("FAIL p2_load_latency: got %0d, required 66", cyc); end
      cmd2_go(4'd11);
      write2(nwr);
      n_test++; if (nwr != 64) begin n_fail++; $display("FAIL p2_write_count: got %0d, required 64", nwr); end
      for (int i = 0; i < 6; i++) begin
         n_test++;
         if (ram2[idx[i]] !== 10'(exp[i])) begin n_fail++; $display("FAIL p2_mirror_px%0d: got %0d, required %0d", idx[i], ram2[idx[i]], exp[i]); end
      end
      for (int i = 0; i < 4; i++) rom2[win[i]] = 10'd1023;
      load2(cyc);
      cmd2_go(4'd7);
      write2(nwr);
      for (int i = 0; i < 4; i++) begin
         n_test++;
         if (ram2[win[i]] !== 10'd1023) begin n_fail++; $display("FAIL p2_avg_px%0d: got %0d, required 1023", win[i], ram2[win[i]]); end
      end
   endtask

   task automatic test_reset_mid_write();
      int k;
      load1();
      cmd1 = 4'd0; cv1 = 1'b1;
      @(negedge clk);
      cv1 = 1'b0;
      k = 0;
      while (!(wv1 === 1'b1 && wa1 === 6'd20) && k < 100) begin @(negedge clk); k++; end
      n_test++; if (wa1 !== 6'd20) begin n_fail++; $display("FAIL rmw_reach20: got %0d, required 20", wa1); end
      rst1 = 1'b1;
      @(negedge clk);
      n_test++; if (wv1 !== 1'b0)   begin n_fail++; $display("FAIL rmw_valid: got %0b, required 0", wv1); end
      n_test++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rmw_busy: got %0b, required 1", busy1); end
      rst1 = 1'b0;
      @(negedge clk);
      n_test++; if (rd1 !== 1'b1 || ra1 !== 6'd0) begin n_fail++; $display("FAIL rmw_restart0: got rd=%0b a=%0d, required rd=1 a=0", rd1, ra1); end
      @(negedge clk);
      n_test++; if (ra1 !== 6'd1) begin n_fail++; $display("FAIL rmw_restart1: got %0d, required 1", ra1); end
   endtask

   task automatic test_bright();
      int nwr, nd, bad;
      int idx [4] = '{27, 28, 35, 36};
`ifdef LCD_CTRL_PARAM_BRIGHT_EN
      int e12 [4] = '{255, 1, 36, 37};
      int e13 [4] = '{254, 0, 34, 35};
`else
      int e12 [4] = '{255, 0, 35, 36};
      int e13 [4] = '{255, 0, 35, 36};
`endif
      rom1[27] = 8'd255;
      rom1[28] = 8'd0;
      load1(); cmd1_go(4'd12); write1(nwr, nd, bad);
      for (int i = 0; i < 4; i++) begin
         n_test++;
         if (ram1[idx[i]] !== 8'(e12[i])) begin n_fail++; $display("FAIL cmd12_px%0d: got %0d, required %0d", idx[i], ram1[idx[i]], e12[i]); end
      end
      load1(); cmd1_go(4'd13); write1(nwr, nd, bad);
      for (int i = 0; i < 4; i++) begin
         n_test++;
         if (ram1[idx[i]] !== 8'(e13[i])) begin n_fail++; $display("FAIL cmd13_px%0d: got %0d, required %0d", idx[i], ram1[idx[i]], e13[i]); end
      end
   endtask

   initial begin
      rst1 = 1'b1; cv1 = 1'b0; cmd1 = 4'd0;
      rst2 = 1'b1; cv2 = 1'b0; cmd2 = 4'd0;
      for (int i = 0; i < 64; i++) begin
         rom1[i] = 8'(i);
         rom2[i] = 10'(i);
      end
      test_reset();
      test_write();
      test_max();
      test_avg();
      test_rot_cw();
      test_boundary();
      test_handshake();
      test_param();
      test_reset_mid_write();
      test_bright();
      $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
Parametrised successor of the fixed 8x8 LCD image controller. It loads a W x H pixel image from IROM into internal storage and executes 2x2-window commands from the host. Supported commands are shift, max/min/average, rotate and mirror. On a write command it streams the image to IRAM. It sits between the host command interface and the IROM/IRAM macros. Image size and pixel width are set by parameters, and the host handshake is cycle-exact.

Parameters:
DW, 8, pixel data width in bits
XW, 3, log2 of image width; W = 2**XW (XW >= 1)
YW, 3, log2 of image height; H = 2**YW (YW >= 1)
(derived localparam AW = XW+YW; pixel index = y*W + x)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  reset, synchronous, active-high
cmd  in  4  command code
cmd_valid  in  1  command strobe
IROM_Q  in  DW  IROM read data, valid one cycle after IROM_A/IROM_rd
IROM_rd  out  1  IROM read enable
IROM_A  out  AW  IROM address
IRAM_valid  out  1  IRAM write strobe
IRAM_D  out  DW  IRAM write data
IRAM_A  out  AW  IRAM address
busy  out  1  block cannot accept a command
done  out  1  one-cycle pulse: write-out complete

Behaviour:
- Reset values:
  - busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0.
  - Operation point (px,py) = (W/2, H/2).
  - Reset at any time aborts the current operation and restarts the LOAD state. Image contents are don't-care until reloaded.
- States: LOAD, IDLE, EXEC, WRITE, DONE.
- LOAD state:
  - From the first cycle after reset, IROM_rd=1 and IROM_A = 0,1,...,N-1 (N = W*H) on consecutive cycles.
  - IROM_Q is captured into image[a] the cycle after address a.
  - IROM_rd drops after address N-1. The last pixel is captured the following cycle.
  - busy falls the cycle after the last capture. Total from reset release to busy=0 is N+2 cycles.
- IDLE handshake:
  - A command is accepted when cmd_valid=1 and busy=0. busy=1 from the next cycle.
  - cmd and cmd_valid are ignored while busy=1.
- Window: pixels P0=(px-1,py-1), P1=(px,py-1), P2=(px-1,py), P3=(px,py). Range px in 1..W-1, py in 1..H-1.
- Single-cycle commands (EXEC): the image and point update at the end of the accept+1 cycle, and busy=0 on the following cycle.
  - 1 up: py-1 if py>1, else unchanged.
  - 2 down: py+1 if py<H-1, else unchanged.
  - 3 left: px-1 if px>1, else unchanged.
  - 4 right: px+1 if px<W-1, else unchanged.
  - 5 max: all four pixels := max(P0..P3).
  - 6 min: all four pixels := min(P0..P3).
  - 7 average: sum is DW+2 bits, result = sum>>2 (floor). All four pixels := result.
  - 8 rotate CCW: P0<=P1, P1<=P3, P3<=P2, P2<=P0.
  - 9 rotate CW: P0<=P2, P2<=P3, P3<=P1, P1<=P0.
  - 10 mirror X: swap P0 with P2, and P1 with P3.
  - 11 mirror Y: swap P0 with P1, and P2 with P3.
  - 12-15: no-op, one busy cycle, unless the optional feature below is enabled.
  - All four window writes for a command occur in the same cycle and use pre-update values.
- Command 0 (WRITE):
  - IRAM_valid=1 with IRAM_A = 0..N-1 and IRAM_D = image[IRAM_A] on N consecutive cycles.
  - Then IRAM_valid=0 and done=1 for exactly one cycle (DONE state).
  - busy=0 on the cycle after done.
  - Image and point are retained, so further commands and writes are legal.
- IRAM_D and IRAM_A hold their last value when IRAM_valid=0.

Optional Feature:
- Macro: LCD_CTRL_PARAM_BRIGHT_EN.
- Enabled: two extra commands operate on the window.
  - 12 brighten: each window pixel := min(p+1, 2**DW-1), saturating.
  - 13 darken: each window pixel := max(p-1, 0), saturating.
  - Both take one busy cycle, the same as other single-cycle commands.
- Disabled: 12 and 13 are no-ops with one busy cycle, and no saturation logic is synthesised.

Test Plan:
- Load, default params: IROM holds image[i]=i. Release reset. Expect IROM_A to sweep 0..63 and busy=0 exactly 66 cycles after reset release. Then cmd 0 -> IRAM receives D=A for A=0..63, followed by a single done pulse.
- Window ops at the default point (4,4): window is pixels 27,28,35,36 = values 27,28,35,36.
  - cmd 5 then cmd 0: all four = 36.
  - After reload, cmd 7: sum 126, all four = 31.
  - After reload, cmd 9: 27<=35, 35<=36, 36<=28, 28<=27.
- Boundary: issue cmd 3 five times, then cmd 1 five times. Point clamps at (1,1). cmd 6 then sets pixels 0,1,8,9 to the min (0).
- Handshake: hold cmd_valid=1 with cmd=4 continuously. The right-shift is accepted only when busy=0. Pulsing cmd_valid while busy=1 has no effect; px increments exactly once per accepted command and stops at 7.
- Parametrisation: XW=4, YW=2, DW=10. Load a 16x4 image. cmd 11 at (8,2), then write. Verify pixels 23/24 and 39/40 are swapped. Average of 1023 x4 = 1023 (no overflow).
- Reset mid-WRITE: assert reset at IRAM_A=20. Expect IRAM_valid=0 the next cycle and busy=1, then the LOAD sequence restarts from IROM_A=0. With LCD_CTRL_PARAM_BRIGHT_EN: pixel 255, cmd 12 -> 255; pixel 0, cmd 13 -> 0.
